matrix_scanner: RTL and testbench

//  Downstream consumer of the 32x16 frame built by the matrix generator.

---
 rtl/matrix_scanner.sv | 175 +++++++++++++++++
 tb/tb_matrix_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scanner.sv
// Snapshots a 32x16 frame and scans it onto a 1/8-scan HUB75 panel (r1 = rows 0-7, r2 = rows 8-15).
// All outputs registered; row period 64*CLK_DIV+1+DISPLAY_CYCLES clocks; no backpressure, enable sampled at frame boundaries.
module matrix_scanner #(
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned DISPLAY_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] matrix_i [15:0],
  input  logic        enable_i,
  output logic        r1_o,
  output logic        r2_o,
  output logic        sclk_o,
  output logic        lat_o,
  output logic        oe_n_o,
  output logic [2:0]  addr_o,
  output logic        frame_done_o
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DISP_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISPLAY_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

  state_e              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [4:0]          bit_q, bit_d;
  logic                phase_q, phase_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                r1_q, r1_d;
  logic                r2_q, r2_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic [2:0]          addr_q, addr_d;
  logic                frame_done_q, frame_done_d;
  logic                snap;
  logic                in_shift;
  logic [31:0]         up_row, lo_row;
  logic [31:0]         shadow_q [15:0];

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    div_d        = div_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;
    snap         = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          snap    = 1'b1;
          row_d   = 3'd0;
          bit_d   = 5'd0;
          div_d   = '0;
          phase_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 5'd31) begin
              state_d = LATCH;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        disp_d  = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (disp_q == DISP_LAST) begin
          bit_d   = 5'd0;
          div_d   = '0;
          phase_d = 1'b0;
          if (row_q != 3'd7) begin
            row_d   = row_q + 3'd1;
            state_d = SHIFT;
          end else begin
            // Back-to-back frames re-snapshot here, so the next frame starts with no idle gap.
            frame_done_d = 1'b1;
            row_d        = 3'd0;
            if (enable_i) begin
              snap    = 1'b1;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          disp_d = disp_q + DISP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they line up with it once registered;
    // on a snapshot the shadow is not yet loaded, so bit 0 comes straight from the input.
    up_row   = snap ? matrix_i[{1'b0, row_d}] : shadow_q[{1'b0, row_d}];
    lo_row   = snap ? matrix_i[{1'b1, row_d}] : shadow_q[{1'b1, row_d}];
    in_shift = (state_d == SHIFT);
    r1_d     = in_shift & up_row[~bit_d];
    r2_d     = in_shift & lo_row[~bit_d];
    sclk_d   = in_shift & phase_d;
    lat_d    = (state_d == LATCH);
    oe_n_d   = (state_d != DISPLAY);
    addr_d   = (state_d == LATCH) ? row_d : addr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      row_q        <= 3'd0;
      bit_q        <= 5'd0;
      phase_q      <= 1'b0;
      div_q        <= '0;
      disp_q       <= '0;
      r1_q         <= 1'b0;
      r2_q         <= 1'b0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      addr_q       <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      disp_q       <= disp_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame storage needs no reset: it is always loaded before any row is shifted out.
  always_ff @(posedge clk_i) begin
    if (snap) begin
      for (int r = 0; r < 16; r++) begin
        shadow_q[r] <= matrix_i[r];
      end
    end
  end

  assign r1_o         = r1_q;
  assign r2_o         = r2_q;
  assign sclk_o       = sclk_q;
  assign lat_o        = lat_q;
  assign oe_n_o       = oe_n_q;
  assign addr_o       = addr_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed bench for matrix_scanner: default instance plus a CLK_DIV=2 / DISPLAY_CYCLES=8 instance.
module tb_matrix_scanner;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, rst2_n, en2;
  logic [31:0] matrix [15:0];
  logic        r1, r2, sclk, lat, oe_n, frame_done;
  logic [2:0]  addr;
  logic        r1b, r2b, sclk2, lat2, oe_n2, fd2;
  logic [2:0]  addr2;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PAT [16] = '{
    32'h1357_9BDF, 32'h0F0F_1234, 32'hC001_D00D, 32'h8421_0001,
    32'h7E00_00FF, 32'h0000_0003, 32'hF000_000F, 32'h2468_ACE0,
    32'h9ABC_DEF0, 32'h0000_0001, 32'h8000_0000, 32'h3C3C_C3C3,
    32'hFFFF_0000, 32'h0001_8000, 32'h5A5A_A5A5, 32'hBEEF_CAFE};

  matrix_scanner dut (
    .clk_i(clk), .rst_ni(rst_n), .matrix_i(matrix), .enable_i(enable),
    .r1_o(r1), .r2_o(r2), .sclk_o(sclk), .lat_o(lat), .oe_n_o(oe_n),
    .addr_o(addr), .frame_done_o(frame_done));

  matrix_scanner #(.CLK_DIV(2), .DISPLAY_CYCLES(8)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .matrix_i(matrix), .enable_i(en2),
    .r1_o(r1b), .r2_o(r2b), .sclk_o(sclk2), .lat_o(lat2), .oe_n_o(oe_n2),
    .addr_o(addr2), .frame_done_o(fd2));

  // Panel model: shift on each sclk rise, capture the shifted word per latched address.
  int          cyc = 0;
  logic        sclk_prev = 1'b0;
  logic [31:0] sh1 = '0, sh2 = '0;
  int          edges = 0;
  logic [31:0] cap1 [8];
  logic [31:0] cap2 [8];
  int          cap_edges [8];
  int          addr_seq [$];
  int          fd_cyc [$];
  int          inv_viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      edges = 0;
    end else begin
      if (sclk === 1'b1 && sclk_prev === 1'b0) begin
        sh1 = {sh1[30:0], r1};
        sh2 = {sh2[30:0], r2};
        edges++;
      end
      if (lat === 1'b1) begin
        cap1[addr]      = sh1;
        cap2[addr]      = sh2;
        cap_edges[addr] = edges;
        edges           = 0;
        addr_seq.push_back(int'(addr));
      end
      if (frame_done === 1'b1) fd_cyc.push_back(cyc);
      if ((lat === 1'b1 || sclk !== sclk_prev) && oe_n !== 1'b1) inv_viol++;
    end
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [8:0] outv();
    return {r1, r2, sclk, lat, oe_n, addr, frame_done};
  endfunction

  // a < 0: any latch pulse; otherwise a latch of that address.
  task automatic wait_lat(input int a, input string tag);
    int n = 0;
    while (!(lat === 1'b1 && (a < 0 || int'(addr) == a)) && n < 4000) begin
      tick();
      n++;
    end
    check(tag, {31'b0, lat === 1'b1}, 32'd1);
  endtask

  task automatic wait_fd(input int k, input string tag);
    int n = 0;
    while (fd_cyc.size() < k && n < 4000) begin
      tick();
      n++;
    end
    check(tag, {31'b0, fd_cyc.size() >= k}, 32'd1);
  endtask

  initial begin
    int          bad;
    logic [31:0] acc;
    int          hi, lo, n, t0;

    rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b0; en2 = 1'b0;
    for (int i = 0; i < 16; i++) matrix[i] = '0;
    repeat (3) tick();
    check("reset_outputs", {23'b0, outv()}, 32'h010);

    rst_n = 1'b1; rst2_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (outv() !== 9'h010) bad++;
    end
    check("idle_hold_100", bad, 0);

    // Single row with only the end bits set.
    matrix[0] = 32'h8000_0001;
    enable = 1'b1;
    wait_lat(-1, "t2_first_lat");
    check("t2_addr", {29'b0, addr}, 0);
    check("t2_r1_word", cap1[0], 32'h8000_0001);
    check("t2_r2_word", cap2[0], 32'h0);
    check("t2_sclk_edges", cap_edges[0], 32);
    tick();
    check("t2_display_entry", {30'b0, lat, oe_n}, 32'h0);

    // Change the input mid-frame: frame 1 must keep showing the old snapshot.
    for (int i = 0; i < 16; i++) matrix[i] = (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    wait_fd(1, "f1_done");
    acc = '0;
    for (int a = 1; a < 8; a++) acc |= cap1[a];
    for (int a = 0; a < 8; a++) acc |= cap2[a];
    check("f1_no_tearing", acc, 32'h0);
    check("f1_last_addr", {29'b0, addr}, 7);
    check("fd_pulse_high", {31'b0, frame_done}, 1);
    tick();
    check("fd_pulse_low", {31'b0, frame_done}, 0);

    wait_fd(2, "f2_done");
    for (int a = 0; a < 8; a++) begin
      check($sformatf("f2_r1_a%0d", a), cap1[a], (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555);
      check($sformatf("f2_r2_a%0d", a), cap2[a], (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555);
    end
    bad = 0;
    if (addr_seq.size() < 16) bad++;
    else for (int i = 0; i < 16; i++) if (addr_seq[i] != i % 8) bad++;
    check("addr_sequence_wrap", bad, 0);
    check("frame_period", fd_cyc[1] - fd_cyc[0], 2568);

    // New data lands during frame 3 and must first appear in frame 4.
    for (int i = 0; i < 16; i++) matrix[i] = PAT[i];
    wait_fd(3, "f3_done");
    check("f3_old_data", cap2[7], 32'h5555_5555);

    wait_lat(3, "f4_row3");
    enable = 1'b0;
    wait_lat(5, "f4_row5");
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    wait_fd(4, "f4_done");
    for (int a = 0; a < 8; a++) begin
      check($sformatf("f4_r1_a%0d", a), cap1[a], PAT[a]);
      check($sformatf("f4_r2_a%0d", a), cap2[a], PAT[a+8]);
    end
    check("f4_period", fd_cyc[3] - fd_cyc[2], 2568);
    check("f4_last_addr", {29'b0, addr}, 7);
    bad = 0;
    repeat (60) begin
      tick();
      if (oe_n !== 1'b1 || sclk !== 1'b0 || lat !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("idle_after_stop", bad, 0);
    check("fd_count_after_stop", fd_cyc.size(), 4);

    // Reset in the middle of row pair 5's on-time.
    enable = 1'b1;
    wait_lat(5, "t6_row5");
    repeat (10) tick();
    check("t6_in_display", {31'b0, oe_n}, 0);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {23'b0, outv()}, 32'h010);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_lat(-1, "t6_restart_lat");
    check("t6_restart_addr", {29'b0, addr}, 0);
    check("t6_restart_r1", cap1[0], PAT[0]);
    check("t6_restart_edges", cap_edges[0], 32);
    check("no_ghosting", inv_viol, 0);

    // CLK_DIV=2 instance: each sclk phase is two cycles, row period 128+1+8.
    en2 = 1'b1;
    n = 0;
    while (sclk2 !== 1'b1 && n < 50) begin tick(); n++; end
    check("d2_sclk_seen", {31'b0, sclk2}, 1);
    check("d2_oe_during_shift", {31'b0, oe_n2}, 1);
    hi = 1;
    tick();
    while (sclk2 === 1'b1 && hi < 10) begin hi++; tick(); end
    lo = 1;
    tick();
    while (sclk2 === 1'b0 && lo < 10) begin lo++; tick(); end
    check("d2_high_phase", hi, 2);
    check("d2_low_phase", lo, 2);
    n = 0;
    while (lat2 !== 1'b1 && n < 400) begin tick(); n++; end
    check("d2_lat0", {31'b0, lat2}, 1);
    check("d2_addr0", {29'b0, addr2}, 0);
    t0 = cyc;
    tick();
    n = 0;
    while (lat2 !== 1'b1 && n < 400) begin tick(); n++; end
    check("d2_row_period", cyc - t0, 137);
    check("d2_addr1", {29'b0, addr2}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
